// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display driver: scans DIGITS digits over one shared segment bus,
// with a double-buffered display image, leading-zero blanking, per-digit dp and blink.
//
// blink phase | meaning
// PH_VISIBLE  | blinking digits are shown normally
// PH_HIDDEN   | blinking digits have all 8 segments off
module seven_segment_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 250,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    output logic                  pending,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic          INV        = (ACTIVE_LOW != 0);

    typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_t;

    logic [PW-1:0]       ps;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    phase_t              phase;
    logic [4*DIGITS-1:0] disp_val, sh_val;
    logic [DIGITS-1:0]   disp_dp, sh_dp, disp_blink, sh_blink;
    logic                disp_blz, sh_blz;

    logic                tc, boundary;
    logic [3:0]          cur_digit;
    logic                cur_dp, cur_blink, cur_lz, allz;
    logic [7:0]          seg_hi;
    logic [DIGITS-1:0]   dig_hi;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    assign tc       = (ps == PS_LAST);
    assign boundary = tc && (idx == IDX_LAST);

    // Walk from the most significant digit down so allz means "this digit and all above are zero".
    always_comb begin
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        allz      = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allz = allz && (disp_val[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_digit = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blink = disp_blink[i];
                cur_lz    = allz && (i != 0);
            end
        end
        seg_hi = {glyph(cur_digit), cur_dp};
        if ((phase == PH_HIDDEN) && cur_blink)
            seg_hi = 8'h00;
        else if (disp_blz && cur_lz)
            seg_hi = {7'b0, cur_dp};
        // First clock of each slot leaves all digits off to avoid ghosting.
        dig_hi = (ps != '0) ? (DIGITS'(1) << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps         <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            phase      <= PH_VISIBLE;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blink <= '0;
            disp_blz   <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_blz     <= 1'b0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= INV ? 8'hFF : 8'h00;
            dig_en     <= {DIGITS{INV}};
        end else begin
            frame_tick <= boundary;
            ps         <= tc ? '0 : ps + 1'b1;
            if (tc)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blink <= blink_en;
                sh_blz   <= blank_lz;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp_val   <= value;
                    disp_dp    <= dp_in;
                    disp_blink <= blink_en;
                    disp_blz   <= blank_lz;
                end else if (pending) begin
                    disp_val   <= sh_val;
                    disp_dp    <= sh_dp;
                    disp_blink <= sh_blink;
                    disp_blz   <= sh_blz;
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
            seg    <= INV ? ~seg_hi : seg_hi;
            dig_en <= INV ? ~dig_hi : dig_hi;
        end
    end

endmodule
